// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: shares one req/gnt/rvalid bus port between fetch (m0) and data (m1) masters,
// with data priority, anti-starvation, request locking and in-order response routing.
module core_bus_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,
    output logic        s_req_o,
    output logic        s_we_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    input  logic        s_gnt_i,
    input  logic        s_rvalid_i,
    input  logic        s_err_i,
    input  logic [31:0] s_rdata_i,
    output logic        unexp_rsp_o
);
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, LOCK_M0, LOCK_M1} state_e;

    state_e                     state_q, state_d;
    logic [3:0]                 starve_q, starve_d;
    logic [MAX_OUTSTANDING-1:0] ids_q, ids_d;
    logic [PW-1:0]              wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       sel_m1, sel_req, full, empty, head, push, pop;

    always_comb begin
        // m1 also wins at the starvation limit when m0 has dropped its request
        sel_m1      = (state_q == LOCK_M1) ||
                      (state_q == IDLE && m1_req_i && (starve_q < 4'(STARVE_LIMIT) || !m0_req_i));
        sel_req     = sel_m1 ? m1_req_i : m0_req_i;
        full        = cnt_q == CW'(MAX_OUTSTANDING);
        empty       = cnt_q == '0;
        head        = ids_q[rptr_q];
        s_req_o     = sel_req && !full && !rst;
        push        = s_req_o && s_gnt_i;
        pop         = s_rvalid_i && !empty;
        m0_gnt_o    = push && !sel_m1;
        m1_gnt_o    = push && sel_m1;
        s_we_o      = sel_m1 && m1_we_i;
        s_be_o      = sel_m1 ? m1_be_i : 4'hF;
        s_addr_o    = sel_m1 ? m1_addr_i : m0_addr_i;
        s_wdata_o   = sel_m1 ? m1_wdata_i : '0;
        m0_rvalid_o = pop && !head && !rst;
        m1_rvalid_o = pop && head && !rst;
        m0_err_o    = m0_rvalid_o && s_err_i;
        m1_err_o    = m1_rvalid_o && s_err_i;
        m0_rdata_o  = s_rdata_i;
        m1_rdata_o  = s_rdata_i;
        unexp_rsp_o = s_rvalid_i && empty && !rst;
    end

    always_comb begin
        state_d = state_q;
        if (s_req_o) state_d = s_gnt_i ? IDLE : (sel_m1 ? LOCK_M1 : LOCK_M0);
        starve_d = (m0_req_i && !m0_gnt_o) ?
                   (starve_q == 4'(STARVE_LIMIT) ? starve_q : starve_q + 4'd1) : 4'd0;
        ids_d = ids_q;
        if (push) ids_d[wptr_q] = sel_m1;
        wptr_d = push ? (wptr_q == PW'(MAX_OUTSTANDING - 1) ? '0 : wptr_q + 1'b1) : wptr_q;
        rptr_d = pop ? (rptr_q == PW'(MAX_OUTSTANDING - 1) ? '0 : rptr_q + 1'b1) : rptr_q;
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
            ids_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            ids_q    <= ids_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter: directed scenario tests for core_bus_arbiter (defaults MAX_OUTSTANDING=2, STARVE_LIMIT=4).
module tb_core_bus_arbiter;
    logic        clk = 0, rst = 1;
    logic        m0_req_i = 0, m1_req_i = 0, m1_we_i = 0;
    logic [31:0] m0_addr_i = 0, m1_addr_i = 0, m1_wdata_i = 0, s_rdata_i = 0;
    logic [3:0]  m1_be_i = 0;
    logic        s_gnt_i = 0, s_rvalid_i = 0, s_err_i = 0;
    logic        m0_gnt_o, m0_rvalid_o, m0_err_o, m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [31:0] m0_rdata_o, m1_rdata_o, s_addr_o, s_wdata_o;
    logic        s_req_o, s_we_o, unexp_rsp_o;
    logic [3:0]  s_be_o;
    int          tests = 0, fails = 0;

    core_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
        .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_addr_o(s_addr_o),
        .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
        .s_err_i(s_err_i), .s_rdata_i(s_rdata_i), .unexp_rsp_o(unexp_rsp_o)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req_i = 0; m1_req_i = 0; m1_we_i = 0; s_gnt_i = 0; s_rvalid_i = 0; s_err_i = 0;
    endtask

    task automatic test_reset();
        m0_req_i = 1; m1_req_i = 1; s_gnt_i = 1; s_rvalid_i = 1;
        #1;
        tests++; if (s_req_o !== 0) begin fails++; $display("FAIL reset_s_req got=%b exp=0", s_req_o); end
        tests++; if ({m0_gnt_o, m1_gnt_o} !== 2'b00) begin fails++; $display("FAIL reset_gnt got=%b exp=00", {m0_gnt_o, m1_gnt_o}); end
        tests++; if ({m0_rvalid_o, m1_rvalid_o, unexp_rsp_o} !== 3'b000) begin fails++; $display("FAIL reset_rsp got=%b exp=000", {m0_rvalid_o, m1_rvalid_o, unexp_rsp_o}); end
        tick();
        idle_inputs();
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_rotation();
        m0_req_i = 1; m1_req_i = 1; s_gnt_i = 1;
        for (int i = 0; i < 11; i++) begin
            logic eg0, eg1, er0, er1;
            if (i == 10) begin m0_req_i = 0; m1_req_i = 0; end
            s_rvalid_i = (i > 0);
            eg1 = (i < 10) && (i % 5 != 4);
            eg0 = (i < 10) && (i % 5 == 4);
            er1 = (i > 0) && ((i - 1) % 5 != 4);
            er0 = (i > 0) && ((i - 1) % 5 == 4);
            #1;
            tests++; if ({m0_gnt_o, m1_gnt_o} !== {eg0, eg1}) begin fails++; $display("FAIL rot_gnt cyc=%0d got=%b exp=%b", i, {m0_gnt_o, m1_gnt_o}, {eg0, eg1}); end
            tests++; if ({m0_rvalid_o, m1_rvalid_o} !== {er0, er1}) begin fails++; $display("FAIL rot_rvalid cyc=%0d got=%b exp=%b", i, {m0_rvalid_o, m1_rvalid_o}, {er0, er1}); end
            tick();
        end
        idle_inputs();
        #1;
        tests++; if (unexp_rsp_o !== 0 || s_req_o !== 0) begin fails++; $display("FAIL rot_idle got=%b%b exp=00", unexp_rsp_o, s_req_o); end
        tick();
    endtask

    task automatic test_lock();
        m0_req_i = 1; m0_addr_i = 32'h100; m1_addr_i = 32'h200;
        for (int i = 0; i < 6; i++) begin
            m1_req_i = (i >= 3);
            m0_req_i = (i <= 4);
            s_gnt_i  = (i >= 4);
            #1;
            if (i <= 4) begin
                tests++; if (s_req_o !== 1 || s_addr_o !== 32'h100) begin fails++; $display("FAIL lock_hold cyc=%0d got=%b/%h exp=1/00000100", i, s_req_o, s_addr_o); end
                tests++; if ({m0_gnt_o, m1_gnt_o} !== {(i == 4), 1'b0}) begin fails++; $display("FAIL lock_gnt cyc=%0d got=%b exp=%b", i, {m0_gnt_o, m1_gnt_o}, {(i == 4), 1'b0}); end
            end else begin
                tests++; if (m1_gnt_o !== 1 || s_addr_o !== 32'h200) begin fails++; $display("FAIL lock_after got=%b/%h exp=1/00000200", m1_gnt_o, s_addr_o); end
            end
            tick();
        end
        idle_inputs();
        s_rvalid_i = 1;
        #1;
        tests++; if ({m0_rvalid_o, m1_rvalid_o} !== 2'b10) begin fails++; $display("FAIL lock_rsp0 got=%b exp=10", {m0_rvalid_o, m1_rvalid_o}); end
        tick();
        #1;
        tests++; if ({m0_rvalid_o, m1_rvalid_o} !== 2'b01) begin fails++; $display("FAIL lock_rsp1 got=%b exp=01", {m0_rvalid_o, m1_rvalid_o}); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_backpressure();
        m1_req_i = 1; m1_addr_i = 32'h300; s_gnt_i = 1;
        for (int i = 0; i < 5; i++) begin
            s_rvalid_i = (i == 3);
            #1;
            tests++; if (m1_gnt_o !== (i != 2 && i != 3)) begin fails++; $display("FAIL bp_gnt cyc=%0d got=%b exp=%b", i, m1_gnt_o, (i != 2 && i != 3)); end
            tests++; if (s_req_o !== (i != 2 && i != 3)) begin fails++; $display("FAIL bp_sreq cyc=%0d got=%b exp=%b", i, s_req_o, (i != 2 && i != 3)); end
            tests++; if (m1_rvalid_o !== (i == 3)) begin fails++; $display("FAIL bp_rvalid cyc=%0d got=%b exp=%b", i, m1_rvalid_o, (i == 3)); end
            tick();
        end
        idle_inputs();
        s_rvalid_i = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if ({m1_rvalid_o, unexp_rsp_o} !== {(i < 2), (i == 2)}) begin fails++; $display("FAIL bp_drain cyc=%0d got=%b exp=%b", i, {m1_rvalid_o, unexp_rsp_o}, {(i < 2), (i == 2)}); end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_payload();
        m1_req_i = 1; m1_we_i = 1; m1_be_i = 4'b0011; m1_addr_i = 32'h40; m1_wdata_i = 32'hDEADBEEF; s_gnt_i = 1;
        #1;
        tests++; if ({m1_gnt_o, s_we_o, s_be_o, s_addr_o, s_wdata_o} !== {1'b1, 1'b1, 4'b0011, 32'h40, 32'hDEADBEEF}) begin fails++; $display("FAIL pay_m1 got=%b %b %b %h %h", m1_gnt_o, s_we_o, s_be_o, s_addr_o, s_wdata_o); end
        tick();
        m1_req_i = 0; m0_req_i = 1; m0_addr_i = 32'h80;
        s_rvalid_i = 1; s_err_i = 0; s_rdata_i = 32'h1111;
        #1;
        tests++; if ({m0_gnt_o, s_we_o, s_be_o, s_addr_o, s_wdata_o} !== {1'b1, 1'b0, 4'hF, 32'h80, 32'h0}) begin fails++; $display("FAIL pay_m0 got=%b %b %b %h %h", m0_gnt_o, s_we_o, s_be_o, s_addr_o, s_wdata_o); end
        tests++; if ({m1_rvalid_o, m0_rvalid_o, m1_rdata_o} !== {2'b10, 32'h1111}) begin fails++; $display("FAIL pay_rsp1 got=%b%b %h exp=10 00001111", m1_rvalid_o, m0_rvalid_o, m1_rdata_o); end
        tick();
        m0_req_i = 0; s_gnt_i = 0; s_err_i = 1; s_rdata_i = 32'h2222;
        #1;
        tests++; if ({m0_rvalid_o, m0_err_o, m1_rvalid_o, m1_err_o, m0_rdata_o} !== {4'b1100, 32'h2222}) begin fails++; $display("FAIL pay_err got=%b%b%b%b %h exp=1100 00002222", m0_rvalid_o, m0_err_o, m1_rvalid_o, m1_err_o, m0_rdata_o); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_unexpected();
        s_rvalid_i = 1;
        #1;
        tests++; if ({unexp_rsp_o, m0_rvalid_o, m1_rvalid_o} !== 3'b100) begin fails++; $display("FAIL unexp_pulse got=%b exp=100", {unexp_rsp_o, m0_rvalid_o, m1_rvalid_o}); end
        tick();
        s_rvalid_i = 0;
        #1;
        tests++; if (unexp_rsp_o !== 0) begin fails++; $display("FAIL unexp_clear got=%b exp=0", unexp_rsp_o); end
        tick();
    endtask

    task automatic test_reset_midop();
        m1_req_i = 1; s_gnt_i = 1;
        tick();
        tick();
        m1_req_i = 0; m0_req_i = 1; s_rvalid_i = 1; rst = 1;
        #1;
        tests++; if ({s_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, unexp_rsp_o} !== 6'b0) begin fails++; $display("FAIL rst_mid got=%b exp=000000", {s_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, unexp_rsp_o}); end
        tick();
        idle_inputs();
        rst = 0;
        tick();
        s_rvalid_i = 1;
        #1;
        tests++; if ({unexp_rsp_o, m0_rvalid_o, m1_rvalid_o} !== 3'b100) begin fails++; $display("FAIL rst_stray got=%b exp=100", {unexp_rsp_o, m0_rvalid_o, m1_rvalid_o}); end
        tick();
        s_rvalid_i = 0; m0_req_i = 1; s_gnt_i = 1;
        #1;
        tests++; if ({m0_gnt_o, m1_gnt_o} !== 2'b10) begin fails++; $display("FAIL rst_newreq got=%b exp=10", {m0_gnt_o, m1_gnt_o}); end
        tick();
        idle_inputs();
        s_rvalid_i = 1;
        #1;
        tests++; if ({m0_rvalid_o, unexp_rsp_o} !== 2'b10) begin fails++; $display("FAIL rst_newrsp got=%b exp=10", {m0_rvalid_o, unexp_rsp_o}); end
        tick();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_lock();
        test_backpressure();
        test_payload();
        test_unexpected();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/core_bus_arbiter.md
# core_bus_arbiter

Shares a single req/gnt/rvalid memory port between the core's instruction-fetch requester (m0) and data-access requester (m1). It sits between the core's instruction and data interfaces and the single-port system bus. It arbitrates with data priority plus an anti-starvation counter, holds a pending request stable until it is granted, and tracks in-flight transactions so that in-order responses are routed back to the requester that issued them.

## Interface
- MAX_OUTSTANDING, default 2: maximum in-flight (granted, not yet responded) transactions; range 1–4.
- STARVE_LIMIT, default 4: number of consecutive cycles m0 may lose arbitration while requesting before it is forced to win; range 1–15.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- m0_req_i  in  1  fetch request
- m0_addr_i  in  32  fetch address
- m0_gnt_o  out  1  fetch request accepted
- m0_rvalid_o  out  1  fetch response valid
- m0_rdata_o  out  32  fetch response data
- m0_err_o  out  1  fetch response error; qualified by m0_rvalid_o
- m1_req_i  in  1  data request
- m1_we_i  in  1  data write enable
- m1_be_i  in  4  data byte enables
- m1_addr_i  in  32  data address
- m1_wdata_i  in  32  data write data
- m1_gnt_o  out  1  data request accepted
- m1_rvalid_o  out  1  data response valid
- m1_rdata_o  out  32  data response data
- m1_err_o  out  1  data response error; qualified by m1_rvalid_o
- s_req_o, s_we_o  out  1  shared-port request and write enable
- s_be_o  out  4  shared-port byte enables
- s_addr_o, s_wdata_o  out  32  shared-port address and write data
- s_gnt_i, s_rvalid_i, s_err_i  in  1  shared-port grant, response valid and response error
- s_rdata_i  in  32  shared-port response data
- unexp_rsp_o  out  1  one-cycle pulse: s_rvalid_i received while no transaction was outstanding

## Operation
- Requester protocol: a master holds req and its payload stable until gnt. A transaction is accepted when s_req_o && s_gnt_i. Responses arrive in order, one per accepted transaction, at least 1 cycle after the grant.
- Lock state: IDLE or LOCKED(owner).
  - In IDLE, arbitrate among masters currently requesting.
  - If s_req_o is driven and s_gnt_i=0, the next state is LOCKED(selected). LOCKED keeps the same owner regardless of other requests.
  - LOCKED returns to IDLE on the cycle the owner is granted.
- Arbitration in IDLE:
  - m1 wins if m1_req_i=1 and starve_cnt < STARVE_LIMIT.
  - Otherwise m0 wins if m0_req_i=1.
  - If starve_cnt == STARVE_LIMIT, m0 wins even if m1 is requesting.
- starve_cnt (4 bits, saturating at STARVE_LIMIT):
  - increments each cycle m0_req_i=1 and m0 is not granted;
  - clears when m0 is granted or m0_req_i=0.
- Mux: s_* payload comes from the selected master. When m0 is selected: s_we_o=0, s_be_o=4'hF, s_wdata_o=0. Only the selected master sees gnt (m*_gnt_o = s_gnt_i && selected && s_req_o).
- In-flight FIFO:
  - depth MAX_OUTSTANDING, 1-bit owner id entries, wrap-around read/write pointers plus a count.
  - Push the owner id on accept; pop on s_rvalid_i.
- Back-pressure: when count == MAX_OUTSTANDING, s_req_o=0 and no gnt is issued, even if a pop occurs the same cycle. Push and pop in the same cycle when not full leave count unchanged.
- Response routing:
  - m0_rdata_o = m1_rdata_o = s_rdata_i always.
  - m*_rvalid_o and m*_err_o = s_rvalid_i / s_err_i gated by head-id == m*, and only when the FIFO is not empty.
- Unexpected response: s_rvalid_i with an empty FIFO asserts no master rvalid, pulses unexp_rsp_o, and leaves all state unchanged.

## Timing
- Fully combinational forwarding:
  - m*_req_i → s_req_o in 0 cycles.
  - s_gnt_i → m*_gnt_o in 0 cycles.
  - s_rvalid_i → m*_rvalid_o in 0 cycles.
- Registered state: lock/owner, starve_cnt, FIFO pointers/count, FIFO entries. Each updates on the rising clk edge.
- Reset (asynchronous assert; deassert synchronized externally):
  - State goes to IDLE, starve_cnt=0, FIFO empty.
  - While rst=1: s_req_o=0, all m*_gnt_o=0, all m*_rvalid_o=0, m*_err_o=0, unexp_rsp_o=0.
- Reset mid-operation discards in-flight ids. A late s_rvalid_i after reset is reported on unexp_rsp_o and is not forwarded.
- Throughput:
  - One accept per cycle when s_gnt_i=1 and the FIFO is not full.
  - With MAX_OUTSTANDING=1 and 1-cycle response latency, throughput is one accept every 2 cycles.

## Test plan
- Both requesting continuously, s_gnt_i=1, 1-cycle rvalid, STARVE_LIMIT=4 → grants go m1 ×4 then m0, repeating. Every rvalid is routed to the issuer in order.
- m0 selected alone with s_gnt_i=0 for 3 cycles, then m1_req_i rises → s_addr_o stays at m0_addr_i and m1 gets no gnt until m0 is granted on cycle 4.
- MAX_OUTSTANDING=2, s_gnt_i=1, rvalid withheld → 2 accepts, then s_req_o=0. A rvalid arriving the same cycle as a new request still blocks that request; the request is granted the next cycle.
- m1 write (we=1, be=4'b0011, wdata=32'hDEADBEEF) then m0 read at 32'h80 → s_* carries the exact payloads, the m0 beat has we=0 and be=4'hF, and err=1 on the second response reaches only m0_err_o.
- s_rvalid_i with an empty FIFO → unexp_rsp_o pulses 1 cycle and both m*_rvalid_o stay 0.
- rst asserted with 2 outstanding → all outputs go 0 immediately. After release, the first stray rvalid pulses unexp_rsp_o and a new m0 request is granted normally.
